// File: rtl/qspi_rx_fifo.sv
// Receive FIFO between the QSPI read path and the host: show-ahead ring buffer with
// byte-order selection, level threshold, sticky overflow/underflow flags and flush.
module qspi_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [31:0]   wr_data,
    output logic          full,
    input  logic          byte_swap,
    input  logic          rd_en,
    output logic [31:0]   rd_data,
    output logic          empty,
    output logic [AW:0]   level,
    input  logic [AW:0]   thresh,
    output logic          thresh_hit,
    output logic          overflow,
    input  logic          clr_err,
    output logic          underflow
);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wa, ra;
    logic [31:0]   wdata_sw;

    assign full       = (level_q == (AW + 1)'(DEPTH));
    assign empty      = (level_q == '0);
    assign level      = level_q;
    assign rd_data    = empty ? 32'h0 : mem_q[rd_ptr_q];
    assign thresh_hit = (thresh != '0) && (level_q >= thresh);
    assign overflow   = ovf_q;
    assign underflow  = udf_q;

    // A pop while full frees the slot the same cycle, so the write may proceed.
    assign wa = wr_en & (~full | rd_en);
    assign ra = rd_en & ~empty;

    assign wdata_sw = byte_swap ? {wr_data[7:0], wr_data[15:8], wr_data[23:16], wr_data[31:24]}
                                : wr_data;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = clr_err ? 1'b0 : ovf_q;
        udf_d    = clr_err ? 1'b0 : udf_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wa) wr_ptr_d = wr_ptr_q + AW'(1);
            if (ra) rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({wa, ra})
                2'b10:   level_d = level_q + (AW + 1)'(1);
                2'b01:   level_d = level_q - (AW + 1)'(1);
                default: level_d = level_q;
            endcase
            // New error events take precedence over clr_err.
            if (wr_en && full && !rd_en) ovf_d = 1'b1;
            if (rd_en && empty)          udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && wa) mem_q[wr_ptr_q] <= wdata_sw;
    end

endmodule

// File: tb/tb_qspi_rx_fifo.sv
// Self-checking bench for qspi_rx_fifo: directed steps then random traffic, all checked
// against a queue-based reference model.
module tb_qspi_rx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset, flush, wr_en, byte_swap, rd_en, clr_err;
    logic [31:0]   wr_data, rd_data;
    logic          full, empty, thresh_hit, overflow, underflow;
    logic [AW:0]   level, thresh;

    int unsigned   tests = 0;
    int unsigned   fails = 0;

    // Reference model state
    logic [31:0]   mq[$];
    bit            m_ovf, m_udf;

    always #5 clk = ~clk;

    qspi_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .byte_swap  (byte_swap),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .level      (level),
        .thresh     (thresh),
        .thresh_hit (thresh_hit),
        .overflow   (overflow),
        .clr_err    (clr_err),
        .underflow  (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit w, input logic [31:0] d, input bit r,
                              input bit fl, input bit clr, input bit rst);
        int unsigned n;
        n = mq.size();
        if (rst) begin
            mq.delete();
            m_ovf = 0;
            m_udf = 0;
        end else if (fl) begin
            mq.delete();
            if (clr) begin m_ovf = 0; m_udf = 0; end
        end else begin
            if (clr) begin m_ovf = 0; m_udf = 0; end
            if (w && n == DEPTH && !r) m_ovf = 1;
            if (r && n == 0)           m_udf = 1;
            if (r && n != 0) void'(mq.pop_front());
            if (w && (n != DEPTH || r))
                mq.push_back(byte_swap ? {d[7:0], d[15:8], d[23:16], d[31:24]} : d);
        end
    endtask

    task automatic check_all(input string tag);
        int unsigned n;
        n = mq.size();
        chk({tag, ".level"},  32'(level),      32'(n));
        chk({tag, ".empty"},  32'(empty),      32'(n == 0));
        chk({tag, ".full"},   32'(full),       32'(n == DEPTH));
        chk({tag, ".rdata"},  rd_data,         (n == 0) ? 32'h0 : mq[0]);
        chk({tag, ".thit"},   32'(thresh_hit), 32'(thresh != 0 && n >= 32'(thresh)));
        chk({tag, ".ovf"},    32'(overflow),   32'(m_ovf));
        chk({tag, ".udf"},    32'(underflow),  32'(m_udf));
    endtask

    task automatic cyc(input string tag, input bit w, input logic [31:0] d, input bit r,
                       input bit fl, input bit clr, input bit rst);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = fl;
        clr_err = clr;
        reset   = rst;
        @(posedge clk);
        #1;
        model_step(w, d, r, fl, clr, rst);
        wr_en = 0; rd_en = 0; flush = 0; clr_err = 0; reset = 0;
        check_all(tag);
    endtask

    initial begin
        reset = 0; flush = 0; wr_en = 0; rd_en = 0; clr_err = 0;
        wr_data = '0; byte_swap = 0; thresh = '0;
        m_ovf = 0; m_udf = 0;
        #2;
        cyc("rst", 0, 0, 0, 0, 0, 1);
        chk("rst.empty_c", 32'(empty), 32'd1);
        chk("rst.rdata_c", rd_data, 32'h0);

        // Basic order and show-ahead
        cyc("w1", 1, 32'h11223344, 0, 0, 0, 0);
        cyc("w2", 1, 32'h55667788, 0, 0, 0, 0);
        chk("basic.level_c", 32'(level), 32'd2);
        chk("basic.head_c", rd_data, 32'h11223344);
        cyc("p1", 0, 0, 1, 0, 0, 0);
        chk("basic.head2_c", rd_data, 32'h55667788);
        cyc("p2", 0, 0, 1, 0, 0, 0);
        chk("basic.empty_c", 32'(empty), 32'd1);

        // Byte swap applied at write time
        byte_swap = 1;
        cyc("sw1", 1, 32'hAABBCCDD, 0, 0, 0, 0);
        chk("swap.head_c", rd_data, 32'hDDCCBBAA);
        byte_swap = 0;
        cyc("sw2", 1, 32'h01020304, 0, 0, 0, 0);
        cyc("sw3", 0, 0, 1, 0, 0, 0);
        chk("swap.head2_c", rd_data, 32'h01020304);
        cyc("sw4", 0, 0, 1, 0, 0, 0);

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) cyc("fill", 1, 32'(i), 0, 0, 0, 0);
        chk("fill.full_c", 32'(full), 32'd1);
        cyc("ovf", 1, 32'hDEAD, 0, 0, 0, 0);
        chk("ovf.flag_c", 32'(overflow), 32'd1);
        chk("ovf.level_c", 32'(level), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain.order_c", rd_data, 32'(i));
            cyc("drain", 0, 0, 1, 0, 0, 0);
        end

        // Simultaneous push/pop while full
        for (int i = 0; i < DEPTH; i++) cyc("fill2", 1, 32'(i), 0, 0, 0, 0);
        cyc("clr", 0, 0, 0, 0, 1, 0);
        cyc("fullrw", 1, 32'h99, 1, 0, 0, 0);
        chk("fullrw.level_c", 32'(level), 32'(DEPTH));
        chk("fullrw.ovf_c", 32'(overflow), 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            chk("drain2.order_c", rd_data, (i == DEPTH) ? 32'h99 : 32'(i));
            cyc("drain2", 0, 0, 1, 0, 0, 0);
        end

        // Underflow with concurrent write, set beats clear
        cyc("udf", 1, 32'h5A, 1, 0, 0, 0);
        chk("udf.flag_c", 32'(underflow), 32'd1);
        chk("udf.head_c", rd_data, 32'h5A);
        cyc("udf.pop", 0, 0, 1, 0, 0, 0);
        cyc("udf.setwins", 0, 0, 1, 0, 1, 0);
        chk("udf.setwins_c", 32'(underflow), 32'd1);
        cyc("udf.clr", 0, 0, 0, 0, 1, 0);

        // Threshold, flush, reset mid-operation
        thresh = 4;
        for (int i = 0; i < 3; i++) cyc("th", 1, 32'(100 + i), 0, 0, 0, 0);
        chk("th.below_c", 32'(thresh_hit), 32'd0);
        cyc("th4", 1, 32'h104, 0, 0, 0, 0);
        chk("th.hit_c", 32'(thresh_hit), 32'd1);
        cyc("flush", 1, 32'hF00D, 1, 1, 0, 0);
        chk("flush.level_c", 32'(level), 32'd0);
        thresh = 0;
        for (int i = 0; i < 5; i++) cyc("th0", 1, 32'(200 + i), 0, 0, 0, 0);
        chk("th0.hit_c", 32'(thresh_hit), 32'd0);
        cyc("rst2", 0, 0, 0, 0, 0, 1);
        chk("rst2.rdata_c", rd_data, 32'h0);
        cyc("rst2.w", 1, 32'h77, 0, 0, 0, 0);
        chk("rst2.head_c", rd_data, 32'h77);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            byte_swap = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) thresh = (AW + 1)'($urandom_range(0, DEPTH + 2));
            cyc("rnd", $urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45,
                $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
                $urandom_range(0, 199) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/qspi_rx_fifo.md
Name: qspi_rx_fifo

Overview:
- Synchronous receive FIFO that sits directly downstream of the QSPI controller FSM read path.
- Accepts 32-bit words the FSM assembles from the flash during DATA/DIR=1 and drives back the full flag the FSM checks before writing.
- Presents a show-ahead read port to the host register/bus side.
- Adds byte-order selection, a level threshold, sticky overflow/underflow error flags and a flush.

Parameters:
- DEPTH, 16, number of 32-bit entries; must be a power of 2, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived localparam, not overridable.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all contents, one-cycle pulse.
- wr_en  input  1  write strobe from the controller (its rx_wen).
- wr_data  input  32  write word from the controller (its rx_data_fifo); first flash byte is in [31:24].
- full  output  1  FIFO full; feeds the controller rx_full.
- byte_swap  input  1  0 = store as received; 1 = store {wr_data[7:0],[15:8],[23:16],[31:24]}.
- rd_en  input  1  host pop strobe.
- rd_data  output  32  head entry (show-ahead); 0 when empty.
- empty  output  1  FIFO empty.
- level  output  AW+1  number of stored entries, 0..DEPTH.
- thresh  input  AW+1  level threshold; 0 disables.
- thresh_hit  output  1  level >= thresh and thresh != 0.
- overflow  output  1  sticky: write dropped because FIFO was full.
- underflow  output  1  sticky: pop attempted while empty.
- clr_err  input  1  clears overflow and underflow.

Behaviour:
- Reset (synchronous, takes effect at the clock edge, overrides all other inputs):
  - wr_ptr=0, rd_ptr=0, level=0.
  - empty=1, full=0, rd_data=0, thresh_hit=0, overflow=0, underflow=0.
  - Memory contents need not be cleared.
- Reset mid-operation: all stored words are lost; the next write after reset lands at entry 0.
- Storage is a DEPTH x 32 array. wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH. level is a separate AW+1-bit register.
- Flags are combinational from registered state: full = (level==DEPTH), empty = (level==0).
- Show-ahead: rd_data = mem[rd_ptr] when !empty, else 0. A word written at edge N is visible on rd_data after edge N when the FIFO was empty (0-cycle read latency after write).
- Write accepted (wa) = wr_en & (!full | rd_en). When full, the simultaneous pop frees the slot.
  - On wa: mem[wr_ptr] <= swapped-or-not data; wr_ptr += 1.
- Read accepted (ra) = rd_en & !empty.
  - On ra: rd_ptr += 1.
  - A same-cycle write into an empty FIFO does not satisfy that cycle's pop.
- level update:
  - +1 on wa & !ra
  - -1 on ra & !wa
  - unchanged on both or neither
- overflow is set when wr_en & full & !rd_en; the word is dropped and the pointer is unchanged.
- underflow is set when rd_en & empty, including when wr_en is asserted the same cycle.
- clr_err clears both sticky flags. If a new error event occurs in the same cycle, set wins.
- flush (priority below reset, above everything else):
  - pointers and level go to 0.
  - same-cycle wr_en/rd_en are ignored and set no flags.
  - sticky flags are not cleared by flush.
- Byte swap is applied at write time, so a mid-stream change of byte_swap affects only later writes.
- thresh_hit is combinational from level and thresh. thresh > DEPTH means it never asserts.
- No other state machine: the block is a two-pointer ring buffer with a level counter. The pointer/level invariant level == (wr_ptr - rd_ptr) mod DEPTH must hold, except level == DEPTH when the pointers are equal and the FIFO is full.

Test Plan:
- Reset, then write 0x11223344, 0x55667788 with byte_swap=0 → level=2, rd_data=0x11223344; pop → rd_data=0x55667788; pop → empty=1, rd_data=0.
- byte_swap=1, write 0xAABBCCDD → rd_data=0xDDCCBBAA; toggle byte_swap to 0, write 0x01020304 → after first pop rd_data=0x01020304.
- DEPTH=16: write 0..15 → full=1, level=16; write 0xDEAD with no pop → overflow=1, level stays 16; pop all 16 → values 0..15 in order, no 0xDEAD.
- While full, assert wr_en=1 (0x99) and rd_en=1 together → level stays 16, overflow stays 0, and 0x99 emerges 16th. Pointers wrap correctly.
- Empty FIFO, rd_en=1 with wr_en=1 (0x5A) → underflow=1, level=1, rd_data=0x5A. Then clr_err together with rd_en on empty → underflow remains 1 (set wins).
- thresh=4: write 3 → thresh_hit=0, write 4th → thresh_hit=1. flush with wr_en=1 → level=0, empty=1, thresh_hit=0, overflow unchanged. thresh=0 at any level → thresh_hit=0. Reset with 5 words stored → level=0, rd_data=0, and the next write appears at the head.
